display_timing_gen: RTL and testbench

//  Generates 1024x768 @ 60 Hz (65 MHz pixel clock) VGA timing.

---
 rtl/display_timing_gen.sv | 109 ++++++++++
 tb/tb_display_timing_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// display_timing_gen: VGA raster timing generator (default 1024x768 @ 60 Hz, 65 MHz).
// Two free-running counters (h_cnt, v_cnt) are decoded combinationally and every
// output is registered from that decode, so all outputs describe the same pixel
// in the same cycle, one clock behind the counters.
module display_timing_gen #(
   parameter int       H_VISIBLE = 1024,
   parameter int       H_FRONT   = 24,
   parameter int       H_SYNC    = 136,
   parameter int       H_BACK    = 160,
   parameter int       V_VISIBLE = 768,
   parameter int       V_FRONT   = 3,
   parameter int       V_SYNC    = 6,
   parameter int       V_BACK    = 29,
   parameter logic     H_POL     = 1'b0,
   parameter logic     V_POL     = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        horiz_sync,
   output logic        vert_sync,
   output logic        video_on,
   output logic [11:0] pixel_row,
   output logic [11:0] pixel_col,
   output logic        line_start,
   output logic        frame_start
);

   localparam logic [11:0] H_VIS   = 12'(H_VISIBLE);
   localparam logic [11:0] HS_BEG  = 12'(H_VISIBLE + H_FRONT);
   localparam logic [11:0] HS_END  = 12'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [11:0] H_LAST  = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [11:0] V_VIS   = 12'(V_VISIBLE);
   localparam logic [11:0] VS_BEG  = 12'(V_VISIBLE + V_FRONT);
   localparam logic [11:0] VS_END  = 12'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [11:0] V_LAST  = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic [11:0] h_next;
   logic [11:0] v_next;
   logic        hs_d;
   logic        vs_d;
   logic        vid_d;
   logic        ls_d;
   logic        fs_d;

   // Next counter values: h wraps at end of line, v steps only on that wrap.
   always_comb begin
      h_next = h_cnt + 12'd1;
      v_next = v_cnt;
      if (h_cnt == H_LAST) begin
         h_next = 12'd0;
         if (v_cnt == V_LAST) begin
            v_next = 12'd0;
         end else begin
            v_next = v_cnt + 12'd1;
         end
      end
   end

   // Decode the current counter position into the pixel's output values.
   always_comb begin
      hs_d  = ~H_POL;
      vs_d  = ~V_POL;
      vid_d = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      ls_d  = (h_cnt == 12'd0);
      fs_d  = (h_cnt == 12'd0) && (v_cnt == 12'd0);
      if ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) begin
         hs_d = H_POL;
      end
      // v_cnt only moves at the line wrap, so this naturally changes at col 0.
      if ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) begin
         vs_d = V_POL;
      end
   end

   // Counter registers; reset aborts any frame in progress.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else begin
         h_cnt <= h_next;
         v_cnt <= v_next;
      end
   end

   // Output registers: one-clock-delayed, mutually aligned view of the counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         horiz_sync  <= ~H_POL;
         vert_sync   <= ~V_POL;
         video_on    <= 1'b0;
         pixel_row   <= 12'd0;
         pixel_col   <= 12'd0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         horiz_sync  <= hs_d;
         vert_sync   <= vs_d;
         video_on    <= vid_d;
         pixel_row   <= v_cnt;
         pixel_col   <= h_cnt;
         line_start  <= ls_d;
         frame_start <= fs_d;
      end
   end

endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: directed bench for display_timing_gen.
// Instance "a" uses the 1024x768 defaults (reset, first lines, hsync, async reset).
// Instance "s" uses a tiny raster (16x11, active-high hsync) so whole frames fit
// in a short run: frame period, vsync width, video_on and pulse counts.
module tb_display_timing_gen;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_a;
   logic        reset_s;
   logic        a_hs, a_vs, a_vid, a_ls, a_fs;
   logic [11:0] a_row, a_col;
   logic        s_hs, s_vs, s_vid, s_ls, s_fs;
   logic [11:0] s_row, s_col;

   int errors = 0;
   int checks = 0;
   logic [23:0] exp_q[$];

   display_timing_gen u_a (
      .clock(clock), .reset_n(reset_a),
      .horiz_sync(a_hs), .vert_sync(a_vs), .video_on(a_vid),
      .pixel_row(a_row), .pixel_col(a_col),
      .line_start(a_ls), .frame_start(a_fs)
   );

   display_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .H_POL(1'b1), .V_POL(1'b0)
   ) u_s (
      .clock(clock), .reset_n(reset_s),
      .horiz_sync(s_hs), .vert_sync(s_vs), .video_on(s_vid),
      .pixel_row(s_row), .pixel_col(s_col),
      .line_start(s_ls), .frame_start(s_fs)
   );

   // Single comparison point: counts every check, reports any mismatch.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected outputs of the default instance at pixel (col,row).
   task automatic check_a(input int col, input int row);
      check_val("a_col", 32'(a_col), col);
      check_val("a_row", 32'(a_row), row);
      check_val("a_video_on", 32'(a_vid), (col < 1024 && row < 768) ? 1 : 0);
      check_val("a_hsync", 32'(a_hs), (col >= 1048 && col < 1184) ? 0 : 1);
      check_val("a_vsync", 32'(a_vs), (row >= 771 && row < 777) ? 0 : 1);
      check_val("a_line_start", 32'(a_ls), (col == 0) ? 1 : 0);
      check_val("a_frame_start", 32'(a_fs), (col == 0 && row == 0) ? 1 : 0);
   endtask

   // Expected outputs of the small instance (hsync active high at 10..12, vsync low rows 7..8).
   task automatic check_s(input int col, input int row);
      logic [23:0] exp_pos;
      exp_q.push_back({12'(row), 12'(col)});
      exp_pos = exp_q.pop_front();
      check_val("s_pos", 32'({s_row, s_col}), 32'(exp_pos));
      check_val("s_video_on", 32'(s_vid), (col < 8 && row < 6) ? 1 : 0);
      check_val("s_hsync", 32'(s_hs), (col >= 10 && col < 13) ? 1 : 0);
      check_val("s_vsync", 32'(s_vs), (row >= 7 && row < 9) ? 0 : 1);
      check_val("s_line_start", 32'(s_ls), (col == 0) ? 1 : 0);
      check_val("s_frame_start", 32'(s_fs), (col == 0 && row == 0) ? 1 : 0);
   endtask

   task automatic check_a_reset(input string tag);
      check_val({tag, "_col"}, 32'(a_col), 0);
      check_val({tag, "_row"}, 32'(a_row), 0);
      check_val({tag, "_video_on"}, 32'(a_vid), 0);
      check_val({tag, "_hsync"}, 32'(a_hs), 1);
      check_val({tag, "_vsync"}, 32'(a_vs), 1);
      check_val({tag, "_line_start"}, 32'(a_ls), 0);
      check_val({tag, "_frame_start"}, 32'(a_fs), 0);
   endtask

   initial begin
      int col, row;
      int hs_low, hs_first, ls_cnt, fs_cnt, vid_cnt;
      int s_fs_cnt, s_fs_idx, s_ls_cnt, s_vid_cnt, s_vs_cnt, s_hs_cnt, s_vs_first;

      // Clock/reset: both instances held in reset for 10 clocks.
      reset_a = 1'b0;
      reset_s = 1'b0;
      repeat (10) @(negedge clock);
      check_a_reset("reset");

      // Release: first clock presents (0,0) with video_on/line/frame pulses.
      reset_a = 1'b1;
      col = 0; row = 0;
      hs_low = 0; hs_first = -1; ls_cnt = 0; fs_cnt = 0; vid_cnt = 0;
      for (int i = 0; i < 3 * 1344 + 500; i++) begin
         @(negedge clock);
         check_a(col, row);
         if (i < 1344 && a_hs == 1'b0) begin
            if (hs_first < 0) hs_first = int'(a_col);
            hs_low++;
         end
         if (i < 3 * 1344) begin
            ls_cnt  += int'(a_ls);
            fs_cnt  += int'(a_fs);
            vid_cnt += int'(a_vid);
         end
         col++;
         if (col == 1344) begin
            col = 0;
            row++;
         end
      end
      check_val("hsync_low_width", hs_low, 136);
      check_val("hsync_first_col", hs_first, 1048);
      check_val("line_starts_3_lines", ls_cnt, 3);
      check_val("frame_starts_3_lines", fs_cnt, 1);
      check_val("video_on_3_lines", vid_cnt, 3 * 1024);

      // Asynchronous reset in the middle of a clock period at (row 3, col 500).
      #2 reset_a = 1'b0;
      #1 check_a_reset("async_reset");
      @(negedge clock);
      check_a_reset("held_reset");
      reset_a = 1'b1;
      @(negedge clock);
      check_a(0, 0);
      @(negedge clock);
      check_a(1, 0);

      // Small raster: two full frames checked pixel by pixel.
      reset_s = 1'b1;
      col = 0; row = 0;
      s_fs_cnt = 0; s_fs_idx = -1; s_ls_cnt = 0; s_vid_cnt = 0;
      s_vs_cnt = 0; s_hs_cnt = 0; s_vs_first = -1;
      for (int i = 0; i < 2 * 176 + 2; i++) begin
         @(negedge clock);
         check_s(col, row);
         if (i < 176) begin
            s_ls_cnt  += int'(s_ls);
            s_vid_cnt += int'(s_vid);
            s_hs_cnt  += int'(s_hs);
            if (s_vs == 1'b0) begin
               if (s_vs_first < 0) s_vs_first = i;
               s_vs_cnt++;
            end
         end
         if (i > 0 && s_fs == 1'b1 && s_fs_idx < 0) s_fs_idx = i;
         if (i < 2 * 176) s_fs_cnt += int'(s_fs);
         col++;
         if (col == 16) begin
            col = 0;
            row++;
            if (row == 11) row = 0;
         end
      end
      check_val("s_frame_period", s_fs_idx, 176);
      check_val("s_frame_starts_2_frames", s_fs_cnt, 2);
      check_val("s_line_starts_frame", s_ls_cnt, 11);
      check_val("s_video_on_frame", s_vid_cnt, 48);
      check_val("s_hsync_active_frame", s_hs_cnt, 33);
      check_val("s_vsync_low_frame", s_vs_cnt, 32);
      check_val("s_vsync_first_cycle", s_vs_first, 7 * 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
